// File: rtl/wb_pkg.sv
// Shared definitions for the MIPS write-back stage.
// Contents: write-back source select codes, load size codes, HI/LO
// write-enable bit positions, and a legality helper for select codes.
package wb_pkg;

  typedef enum logic [2:0] {
    WB_NONE = 3'b000,
    WB_ALU  = 3'b001,
    WB_RS   = 3'b010,
    WB_RAM  = 3'b011,
    WB_HI   = 3'b100,
    WB_LO   = 3'b101,
    WB_PC8  = 3'b110,
    WB_ILL  = 3'b111
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_BYTE = 2'd0,
    LD_HALF = 2'd1,
    LD_WORD = 2'd2,
    LD_RSVD = 2'd3
  } ld_size_e;

  localparam int unsigned HILO_LO = 0;
  localparam int unsigned HILO_HI = 1;

  function automatic logic wb_sel_legal(wb_sel_e sel);
    return (sel != WB_NONE) && (sel != WB_ILL);
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: selects the addressed byte/half/word from a raw RAM
// word and zero- or sign-extends it to the datapath width.
// Ports:
//   ram_i   raw load word
//   off_i   byte offset (address[1:0]); bit 0 ignored for halfwords
//   size_i  0=byte, 1=half, 2=word, 3=reserved (treated as word)
//   uns_i   zero-extend instead of sign-extend
//   data_o  aligned, extended result
module load_align
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] ram_i,
  input  logic [1:0]        off_i,
  input  logic [1:0]        size_i,
  input  logic              uns_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = ram_i[{off_i, 3'b000} +: 8];
    half_v = ram_i[{off_i[1], 4'b0000} +: 16];
    case (ld_size_e'(size_i))
      LD_BYTE: data_o = {{(DATA_W-8){byte_v[7] & ~uns_i}}, byte_v};
      LD_HALF: data_o = {{(DATA_W-16){half_v[15] & ~uns_i}}, half_v};
      default: data_o = ram_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered MIPS write-back stage. Captures the MEM-stage bundle (with
// load data already aligned) into a one-entry register, drives the
// register-file write port one cycle later, and owns HI/LO.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   stall, flush          hazard-unit controls (flush wins over stall)
//   in_valid ... lo_in    MEM-stage bundle
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   hi_o, lo_o            architectural HI/LO including pending-write bypass
//   wb_valid              stage holds a valid instruction
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RF_AW    = 5,
  parameter int unsigned LINK_OFF = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [2:0]        rf_wsel,
  input  logic              rf_we_in,
  input  logic [RF_AW-1:0]  rf_waddr_in,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] rs_in,
  input  logic [DATA_W-1:0] ram_in,
  input  logic [1:0]        ld_off,
  input  logic [1:0]        ld_size,
  input  logic              ld_uns,
  input  logic [1:0]        hilo_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              wb_valid
);

  logic [DATA_W-1:0] ld_aligned;

  logic              valid_q, valid_d;
  logic              we_q;
  logic [RF_AW-1:0]  waddr_q;
  wb_sel_e           wsel_q;
  logic [DATA_W-1:0] pc_q, alu_q, rs_q, ld_q;
  logic [1:0]        hilo_we_q;
  logic [DATA_W-1:0] hi_new_q, lo_new_q;
  logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;

  logic              commit;
  logic [DATA_W-1:0] pc8;

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .ram_i  (ram_in),
    .off_i  (ld_off),
    .size_i (ld_size),
    .uns_i  (ld_uns),
    .data_o (ld_aligned)
  );

  // The bundle held in the stage retires in any cycle it is valid and not stalled.
  assign commit = valid_q & ~stall;

  always_comb begin
    if (flush)      valid_d = 1'b0;
    else if (stall) valid_d = valid_q;
    else            valid_d = in_valid;
    hi_d = (commit & hilo_we_q[HILO_HI]) ? hi_new_q : hi_q;
    lo_d = (commit & hilo_we_q[HILO_LO]) ? lo_new_q : lo_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wsel_q    <= WB_NONE;
      pc_q      <= '0;
      alu_q     <= '0;
      rs_q      <= '0;
      ld_q      <= '0;
      hilo_we_q <= '0;
      hi_new_q  <= '0;
      lo_new_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (!stall) begin
        we_q      <= rf_we_in;
        waddr_q   <= rf_waddr_in;
        wsel_q    <= wb_sel_e'(rf_wsel);
        pc_q      <= pc;
        alu_q     <= alu_in;
        rs_q      <= rs_in;
        ld_q      <= ld_aligned;
        hilo_we_q <= hilo_we;
        hi_new_q  <= hi_in;
        lo_new_q  <= lo_in;
      end
    end
  end

  // A pending HI/LO write in the stage is visible before it commits.
  always_comb begin
    hi_o = (valid_q & hilo_we_q[HILO_HI]) ? hi_new_q : hi_q;
    lo_o = (valid_q & hilo_we_q[HILO_LO]) ? lo_new_q : lo_q;
  end

  assign pc8 = pc_q + DATA_W'(LINK_OFF);

  // One-hot AND-OR select; unused codes decode to no term and yield zero.
  always_comb begin
    rf_wdata = ({DATA_W{wsel_q == WB_ALU}} & alu_q)
             | ({DATA_W{wsel_q == WB_RS }} & rs_q)
             | ({DATA_W{wsel_q == WB_RAM}} & ld_q)
             | ({DATA_W{wsel_q == WB_HI }} & hi_o)
             | ({DATA_W{wsel_q == WB_LO }} & lo_o)
             | ({DATA_W{wsel_q == WB_PC8}} & pc8);
    rf_we    = valid_q & we_q & (|waddr_q) & wb_sel_legal(wsel_q);
  end

  assign rf_waddr = waddr_q;
  assign wb_valid = valid_q;

endmodule
